// File: rtl/multdiv_arb_pkg.sv
// Shared encodings for the mult/div issue arbiter: FSM states and unit operation codes.
package multdiv_arb_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StWb    = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam logic MdMul = 1'b0;
  localparam logic MdDiv = 1'b1;

endpackage

// File: rtl/md_watchdog.sv
// Cycle counter that flags a mult/div operation stuck for LIMIT enabled cycles.
// Only instantiated when MULTDIV_TIMEOUT_EN is defined.
module md_watchdog
  import multdiv_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);

  logic [CntW-1:0] cnt_q;

  // Expires on the LIMIT-th enabled cycle after a clear.
  assign expired = enable && (cnt_q >= CntW'(LIMIT - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/multdiv_issue_arbiter.sv
// Serialises mult/div requests from two DX lanes onto one shared unit; lane 0 (older) wins.
// Define MULTDIV_TIMEOUT_EN to add a RUN/DRAIN watchdog driving md_timeout.
module multdiv_issue_arbiter
  import multdiv_arb_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned REG_W          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              op0,
  input  logic              op1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  input  logic [REG_W-1:0]  rd0,
  input  logic [REG_W-1:0]  rd1,
  input  logic              flush,
  input  logic              md_ready,
  input  logic [DATA_W-1:0] md_result,
  output logic              md_start,
  output logic              md_op,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_lane,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              md_timeout
);

  logic [1:0]        state_q, state_d;
  logic              lane_q, lane_d, op_q, op_d, first_q, first_d, timeout_q, timeout_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              issue0, issue1, md_done, wb_fire, done0_eff, done1_eff, stall_raw;
  logic              wd_expired;

  assign issue0  = req0 & ~done0_q;
  assign issue1  = req1 & ~done1_q;
  // The unit cannot answer in its own start cycle.
  assign md_done = md_ready & ~first_q;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    res_d     = res_q;
    first_d   = 1'b0;
    timeout_d = timeout_q;
    wb_fire   = 1'b0;
    case (state_q)
      StIdle: begin
        if (!flush && issue0) begin
          {lane_d, op_d, a_d, b_d, rd_d} = {1'b0, op0, a0, b0, rd0};
          state_d = StRun;
          first_d = 1'b1;
        end else if (!flush && issue1) begin
          {lane_d, op_d, a_d, b_d, rd_d} = {1'b1, op1, a1, b1, rd1};
          state_d = StRun;
          first_d = 1'b1;
        end
      end
      StRun: begin
        if (flush) begin
          state_d = md_done ? StIdle : StDrain;
        end else if (md_done) begin
          res_d   = md_result;
          state_d = StWb;
        end else if (wd_expired) begin
          res_d     = '0;
          timeout_d = 1'b1;
          state_d   = StWb;
        end
      end
      StWb: begin
        wb_fire = ~flush;
        if (!flush && !lane_q && issue1) begin
          {lane_d, op_d, a_d, b_d, rd_d} = {1'b1, op1, a1, b1, rd1};
          state_d = StRun;
          first_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        if (md_ready) begin
          state_d = StIdle;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
    endcase
  end

  // The lane writing back this cycle already counts as done for the stall decision.
  assign done0_eff = done0_q | (wb_fire & ~lane_q);
  assign done1_eff = done1_q | (wb_fire & lane_q);
  assign stall_raw = (req0 & ~done0_eff) | (req1 & ~done1_eff);
  assign done0_d   = (flush || !stall_raw) ? 1'b0 : done0_eff;
  assign done1_d   = (flush || !stall_raw) ? 1'b0 : done1_eff;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      lane_q    <= 1'b0;
      op_q      <= 1'b0;
      first_q   <= 1'b0;
      timeout_q <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      op_q      <= op_d;
      first_q   <= first_d;
      timeout_q <= timeout_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      rd_q      <= rd_d;
    end
  end

`ifdef MULTDIV_TIMEOUT_EN
  logic wd_clear, wd_enable;

  assign wd_clear  = (state_d == StRun) && (state_q != StRun);
  assign wd_enable = (state_q == StRun) || (state_q == StDrain);

  md_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_expired         = 1'b0;
`endif

  // Outputs are forced quiet while reset is asserted, since the state only clears on the edge.
  assign md_start   = ~reset & (state_q == StRun) & first_q;
  assign md_op      = op_q;
  assign md_a       = a_q;
  assign md_b       = b_q;
  assign stall      = ~reset & stall_raw;
  assign wb_valid   = ~reset & wb_fire;
  assign wb_lane    = wb_valid & lane_q;
  assign wb_rd      = wb_valid ? rd_q : '0;
  assign wb_data    = wb_valid ? res_q : '0;
  assign md_timeout = ~reset & timeout_q;

endmodule

// File: tb/tb_multdiv_issue_arbiter.sv
// Self-checking bench for multdiv_issue_arbiter: per-scenario tasks plus a writeback scoreboard.
// With MULTDIV_TIMEOUT_EN defined the watchdog scenario runs; otherwise an indefinite wait is checked.
module tb_multdiv_issue_arbiter;
  import multdiv_arb_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic          clock = 1'b0;
  logic          reset, req0, req1, op0, op1, flush, md_ready;
  logic [DW-1:0] a0, b0, a1, b1, md_result;
  logic [RW-1:0] rd0, rd1;
  logic          md_start, md_op, stall, wb_valid, wb_lane, md_timeout;
  logic [DW-1:0] md_a, md_b, wb_data;
  logic [RW-1:0] wb_rd;

  typedef struct packed {
    logic          lane;
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  wb_seen = 0;

  multdiv_issue_arbiter #(
    .DATA_W        (DW),
    .REG_W         (RW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .op0       (op0),
    .op1       (op1),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .rd0       (rd0),
    .rd1       (rd1),
    .flush     (flush),
    .md_ready  (md_ready),
    .md_result (md_result),
    .md_start  (md_start),
    .md_op     (md_op),
    .md_a      (md_a),
    .md_b      (md_b),
    .stall     (stall),
    .wb_valid  (wb_valid),
    .wb_lane   (wb_lane),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .md_timeout(md_timeout)
  );

  always #5 clock = ~clock;

  // Scoreboard: every writeback must match the oldest expected entry.
  always @(negedge clock) begin
    wb_t got;
    wb_t want;
    if (wb_valid) begin
      wb_seen++;
      n_tests++;
      got = {wb_lane, wb_rd, wb_data};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got lane=%0d rd=%0d data=%0d, required no writeback",
                 got.lane, got.rd, got.data);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL wb_data: got lane=%0d rd=%0d data=%0d, required lane=%0d rd=%0d data=%0d",
                   got.lane, got.rd, got.data, want.lane, want.rd, want.data);
        end
      end
    end
  end

  task automatic clear_inputs();
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; op0 = MdMul; op1 = MdMul; flush = 1'b0;
    md_ready = 1'b0; md_result = 32'hdead_beef;
    a0 = 32'h55; b0 = 32'h66; a1 = 32'h77; b1 = 32'h88; rd0 = 5'd30; rd1 = 5'd31;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    req0  = 1'b1;
    req1  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
      end
      @(negedge clock);
      n_tests++;
      if ({md_start, wb_valid, stall, md_timeout, wb_lane, wb_rd, wb_data} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs c%0d: start=%b wbv=%b stall=%b tmo=%b lane=%b rd=%0d data=%0d, required all 0",
                 c, md_start, wb_valid, stall, md_timeout, wb_lane, wb_rd, wb_data);
      end
      if (c >= 2) begin
        n_tests++;
        if ({md_op, md_a, md_b} !== '0) begin
          n_fail++;
          $display("FAIL reset_latched c%0d: op=%b a=%0d b=%0d, required 0", c, md_op, md_a, md_b);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_lane0_mult();
    logic [2:0] exp_v;
    clear_inputs();
    req0 = 1'b1; op0 = MdMul; a0 = 32'd6; b0 = 32'd7; rd0 = 5'd3;
    exp_q.push_back('{1'b0, 5'd3, 32'd42});
    for (int c = 0; c <= 6; c++) begin
      md_ready  = (c == 4);
      md_result = (c == 4) ? 32'd42 : 32'hdead_beef;
      if (c == 6) req0 = 1'b0;
      @(negedge clock);
      exp_v = {c == 1, c <= 4, c == 5};
      n_tests++;
      if ({md_start, stall, wb_valid} !== exp_v) begin
        n_fail++;
        $display("FAIL lane0_ctrl c%0d: start/stall/wbv=%b, required %b", c,
                 {md_start, stall, wb_valid}, exp_v);
      end
      if (c >= 1 && c <= 4) begin
        n_tests++;
        if ({md_op, md_a, md_b} !== {MdMul, 32'd6, 32'd7}) begin
          n_fail++;
          $display("FAIL lane0_operands c%0d: op=%b a=%0d b=%0d, required 0 6 7", c, md_op, md_a,
                   md_b);
        end
      end
      next_cycle();
    end
  endtask

  // Also checks that md_ready in the start cycle is ignored.
  task automatic test_lane1_only();
    logic [2:0] exp_v;
    clear_inputs();
    req1 = 1'b1; op1 = MdDiv; a1 = 32'd143; b1 = 32'd11; rd1 = 5'd7;
    exp_q.push_back('{1'b1, 5'd7, 32'd13});
    for (int c = 0; c <= 4; c++) begin
      md_ready  = (c == 1) || (c == 2);
      md_result = (c == 2) ? 32'd13 : 32'd999;
      if (c == 4) req1 = 1'b0;
      @(negedge clock);
      exp_v = {c == 1, c <= 2, c == 3};
      n_tests++;
      if ({md_start, stall, wb_valid} !== exp_v) begin
        n_fail++;
        $display("FAIL lane1_ctrl c%0d: start/stall/wbv=%b, required %b", c,
                 {md_start, stall, wb_valid}, exp_v);
      end
      if (c == 1) begin
        n_tests++;
        if ({md_op, md_a, md_b} !== {MdDiv, 32'd143, 32'd11}) begin
          n_fail++;
          $display("FAIL lane1_operands: op=%b a=%0d b=%0d, required 1 143 11", md_op, md_a, md_b);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_both_lanes();
    logic [2:0] exp_v;
    clear_inputs();
    req0 = 1'b1; op0 = MdDiv; a0 = 32'd100; b0 = 32'd5; rd0 = 5'd4;
    req1 = 1'b1; op1 = MdMul; a1 = 32'd3; b1 = 32'd3; rd1 = 5'd9;
    for (int c = 0; c <= 7; c++) begin
      md_ready  = (c == 2) || (c == 5);
      md_result = (c == 2) ? 32'd20 : 32'd9;
      if (c == 2) exp_q.push_back('{1'b0, 5'd4, 32'd20});
      if (c == 5) exp_q.push_back('{1'b1, 5'd9, 32'd9});
      if (c == 7) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      @(negedge clock);
      exp_v = {c == 1 || c == 4, c <= 5, c == 3 || c == 6};
      n_tests++;
      if ({md_start, stall, wb_valid} !== exp_v) begin
        n_fail++;
        $display("FAIL both_ctrl c%0d: start/stall/wbv=%b, required %b", c,
                 {md_start, stall, wb_valid}, exp_v);
      end
      if (c == 1 || c == 4) begin
        n_tests++;
        if ({md_op, md_a, md_b} !== ((c == 1) ? {MdDiv, 32'd100, 32'd5} : {MdMul, 32'd3, 32'd3}))
        begin
          n_fail++;
          $display("FAIL both_operands c%0d: op=%b a=%0d b=%0d", c, md_op, md_a, md_b);
        end
      end
      next_cycle();
    end
  endtask

  // Flush in the second RUN cycle drains a late result, then a fresh request issues normally.
  task automatic test_flush_drain();
    logic [2:0] exp_v;
    int         base;
    clear_inputs();
    base = wb_seen;
    req0 = 1'b1; a0 = 32'd2; b0 = 32'd3; rd0 = 5'd5;
    for (int c = 0; c <= 9; c++) begin
      flush     = (c == 2);
      md_ready  = (c == 4) || (c == 7);
      md_result = (c == 4) ? 32'd555 : 32'd20;
      if (c == 2) req0 = 1'b0;
      if (c == 3) begin
        req0 = 1'b1; a0 = 32'd4; b0 = 32'd5; rd0 = 5'd6;
      end
      if (c == 7) exp_q.push_back('{1'b0, 5'd6, 32'd20});
      if (c == 9) req0 = 1'b0;
      @(negedge clock);
      exp_v = {c == 1 || c == 6, c <= 1 || (c >= 3 && c <= 7), c == 8};
      n_tests++;
      if ({md_start, stall, wb_valid} !== exp_v) begin
        n_fail++;
        $display("FAIL flush_ctrl c%0d: start/stall/wbv=%b, required %b", c,
                 {md_start, stall, wb_valid}, exp_v);
      end
      if (c == 6) begin
        n_tests++;
        if ({md_a, md_b} !== {32'd4, 32'd5}) begin
          n_fail++;
          $display("FAIL flush_reissue: a=%0d b=%0d, required 4 5", md_a, md_b);
        end
      end
      next_cycle();
    end
    n_tests++;
    if (wb_seen - base !== 1) begin
      n_fail++;
      $display("FAIL flush_wb_count: got %0d writebacks, required 1", wb_seen - base);
    end
  endtask

  // Flush coinciding with md_ready goes straight to IDLE: the next request starts one cycle later.
  task automatic test_flush_with_ready();
    logic [2:0] exp_v;
    clear_inputs();
    req1 = 1'b1; rd1 = 5'd1;
    for (int c = 0; c <= 7; c++) begin
      flush     = (c == 2);
      md_ready  = (c == 2) || (c == 5);
      md_result = (c == 2) ? 32'd123 : 32'd81;
      if (c == 2) req1 = 1'b0;
      if (c == 3) begin
        req0 = 1'b1; a0 = 32'd9; b0 = 32'd9; rd0 = 5'd2;
      end
      if (c == 5) exp_q.push_back('{1'b0, 5'd2, 32'd81});
      if (c == 7) req0 = 1'b0;
      @(negedge clock);
      exp_v = {c == 1 || c == 4, c <= 1 || (c >= 3 && c <= 5), c == 6};
      n_tests++;
      if ({md_start, stall, wb_valid} !== exp_v) begin
        n_fail++;
        $display("FAIL flush_ready_ctrl c%0d: start/stall/wbv=%b, required %b", c,
                 {md_start, stall, wb_valid}, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_run();
    logic [1:0] exp_v;
    int         base;
    clear_inputs();
    base = wb_seen;
    req1 = 1'b1; rd1 = 5'd2;
    for (int c = 0; c <= 6; c++) begin
      reset     = (c == 2);
      md_ready  = (c == 4);
      md_result = 32'd77;
      if (c == 2) begin
        req1 = 1'b0;
        req0 = 1'b1;
      end
      if (c == 3) req0 = 1'b0;
      @(negedge clock);
      exp_v = {c == 1, c <= 1};
      n_tests++;
      if ({md_start, stall} !== exp_v || {wb_valid, wb_lane, wb_rd, wb_data, md_timeout} !== '0)
      begin
        n_fail++;
        $display("FAIL reset_mid_run c%0d: start/stall=%b wbv=%b rd=%0d data=%0d tmo=%b, required %b and 0s",
                 c, {md_start, stall}, wb_valid, wb_rd, wb_data, md_timeout, exp_v);
      end
      next_cycle();
    end
    n_tests++;
    if (wb_seen !== base) begin
      n_fail++;
      $display("FAIL reset_stale_wb: got %0d writebacks, required 0", wb_seen - base);
    end
  endtask

`ifdef MULTDIV_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] exp_v;
    clear_inputs();
    req0 = 1'b1; a0 = 32'd1; b0 = 32'd0; rd0 = 5'd8;
    exp_q.push_back('{1'b0, 5'd8, 32'd0});
    for (int c = 0; c <= 11; c++) begin
      if (c == 10) req0 = 1'b0;
      @(negedge clock);
      exp_v = {c == 1, c <= 8, c == 9, c >= 9};
      n_tests++;
      if ({md_start, stall, wb_valid, md_timeout} !== exp_v) begin
        n_fail++;
        $display("FAIL timeout_ctrl c%0d: start/stall/wbv/tmo=%b, required %b", c,
                 {md_start, stall, wb_valid, md_timeout}, exp_v);
      end
      next_cycle();
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    n_tests++;
    if (md_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_reset: md_timeout=%b, required 0", md_timeout);
    end
    next_cycle();
  endtask
`else
  task automatic test_no_timeout();
    logic [3:0] exp_v;
    int         base;
    clear_inputs();
    base = wb_seen;
    req0 = 1'b1; a0 = 32'd1; b0 = 32'd0; rd0 = 5'd8;
    for (int c = 0; c <= 33; c++) begin
      flush    = (c == 30);
      md_ready = (c == 32);
      if (c == 30) req0 = 1'b0;
      @(negedge clock);
      exp_v = {c == 1, c < 30, 1'b0, 1'b0};
      n_tests++;
      if ({md_start, stall, wb_valid, md_timeout} !== exp_v) begin
        n_fail++;
        $display("FAIL no_timeout_ctrl c%0d: start/stall/wbv/tmo=%b, required %b", c,
                 {md_start, stall, wb_valid, md_timeout}, exp_v);
      end
      next_cycle();
    end
    n_tests++;
    if (wb_seen !== base) begin
      n_fail++;
      $display("FAIL no_timeout_wb: got %0d writebacks, required 0", wb_seen - base);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_lane0_mult();
    test_lane1_only();
    test_both_lanes();
    test_flush_drain();
    test_flush_with_ready();
    test_reset_mid_run();
`ifdef MULTDIV_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected writebacks missing, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_issue_arbiter.md
MULTDIV_ISSUE_ARBITER -- requirements
Module: multdiv_issue_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand/result width.
REQ-002 SHALL have parameter REG_W, default 5, meaning destination register index width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning watchdog limit (used only under MULTDIV_TIMEOUT_EN).
REQ-004 SHALL have ports, in order:
- clock, in, 1: the single clock.
- reset, in, 1: synchronous, active-high.
- req0, req1, in, 1 each: lane 0 (older) / lane 1 (younger) DX instruction is mult/div.
- op0, op1, in, 1 each: 0 = mult, 1 = div.
- a0, b0, a1, b1, in, DATA_W each: lane operands.
- rd0, rd1, in, REG_W each: lane destinations.
- flush, in, 1: kill in-flight pair.
- md_ready, in, 1: shared unit has a result.
- md_result, in, DATA_W: unit result.
- md_start, out, 1: start pulse to unit.
- md_op, out, 1: operation to unit.
- md_a, md_b, out, DATA_W each: operands to unit.
- stall, out, 1: hold PC, FD and DX, both lanes.
- wb_valid, out, 1: result writeback strobe.
- wb_lane, out, 1: lane of the result.
- wb_rd, out, REG_W: destination of the result.
- wb_data, out, DATA_W: result data.
- md_timeout, out, 1: sticky watchdog error.

Function
REQ-005 SHALL implement FSM states IDLE, RUN, WB, DRAIN.
REQ-006 IDLE: req0 & !done0 SHALL latch op0/a0/b0/rd0, set lane_q=0 and go to RUN; otherwise req1 & !done1 SHALL latch lane 1 and go to RUN. Lane 0 always has priority.
REQ-007 md_start SHALL be 1 for exactly the first RUN cycle. md_op/md_a/md_b SHALL come from latched registers and stay stable throughout RUN.
REQ-008 RUN: md_ready SHALL be ignored in the md_start cycle. Afterwards, md_ready SHALL capture md_result and go to WB.
REQ-009 WB: wb_valid SHALL be 1 for exactly one cycle, with wb_lane=lane_q, wb_rd and wb_data from latched/captured values, and SHALL set done[lane_q].
REQ-010 WB with lane_q=0 and req1 & !done1 SHALL latch lane 1 and go directly to RUN. Otherwise WB SHALL go to IDLE.
REQ-011 stall SHALL be combinational: (req0 & !done0') | (req1 & !done1'), where done' includes the lane completing in the current WB cycle.
REQ-012 The cycle in which stall=0 SHALL clear done0 and done1, because the pair advances on that edge.
REQ-013 Minimum single-op latency: request in IDLE at cycle 0; md_start at cycle 1; md_ready earliest at cycle 2; wb_valid at cycle 3 with stall=0.
REQ-014 flush SHALL clear done0/done1 and suppress any wb_valid that cycle.
REQ-015 flush in RUN SHALL go to DRAIN. flush in WB SHALL go to IDLE. flush in IDLE SHALL stay in IDLE and issue nothing that cycle.
REQ-016 DRAIN SHALL wait for md_ready, discard md_result, emit no wb_valid, then go to IDLE. stall SHALL stay 1 in DRAIN if req is present.
REQ-017 Simultaneous flush and md_ready in RUN SHALL go to IDLE with no writeback.
REQ-018 A mult/div in only lane 1, with a non-mult lane 0, SHALL be served as the lane-1 path with the same latency.

Reset
REQ-019 reset SHALL set state=IDLE, done0=done1=0, lane_q=0 and all latched registers to 0.
REQ-020 During and after reset, md_start, wb_valid, stall, md_timeout and wb_* SHALL all be 0.
REQ-021 reset mid-RUN SHALL abandon the op. Any later md_ready arriving in IDLE SHALL be ignored.

Configuration
REQ-022 With macro MULTDIV_TIMEOUT_EN defined, a counter SHALL count RUN/DRAIN cycles and clear on entry to RUN.
REQ-023 Under the macro, reaching TIMEOUT_CYCLES without md_ready SHALL set md_timeout (sticky until reset). From RUN it SHALL go to WB with wb_data=0; from DRAIN it SHALL go to IDLE.
REQ-024 Without the macro, no counter SHALL exist, md_timeout SHALL be tied to 0, and RUN/DRAIN SHALL wait indefinitely.

Structure
REQ-025 Shared package multdiv_arb_pkg SHALL hold the state encoding (IDLE=0, RUN=1, WB=2, DRAIN=3) and the op encoding (MD_MUL=0, MD_DIV=1).
REQ-026 The watchdog SHALL be a sub-module md_watchdog (clear, enable, expired), instantiated only under MULTDIV_TIMEOUT_EN.

Verification
REQ-027 Lane-0 mult: req0=1, a0=6, b0=7, rd0=3, md_ready at cycle 4 with md_result=42 -> md_start at cycle 1 only; wb_valid at cycle 5 with wb_lane=0, wb_rd=3, wb_data=42; stall=1 for cycles 0-4 and 0 at cycle 5.
REQ-028 Both lanes: req0 div 100/5 rd=4, req1 mult 3*3 rd=9 -> lane 0 writeback first (data 20, stall still 1), then WB->RUN with md_start for lane 1, then writeback 9 with stall=0.
REQ-029 Lane-1 only: req1=1, rd1=7 -> wb_lane=1, wb_rd=7, same latency as REQ-027.
REQ-030 flush in the second RUN cycle, md_ready two cycles later -> DRAIN, no wb_valid; next request issues from IDLE normally.
REQ-031 reset asserted mid-RUN, then a stale md_ready -> all outputs 0 and no writeback.
REQ-032 (MULTDIV_TIMEOUT_EN, TIMEOUT_CYCLES=8) md_ready never asserted -> md_timeout=1, wb_valid with wb_data=0, stall released.
